// File: rtl/dma_wr_engine.sv
// dma_wr_engine
//   Upstream-write DMA engine behind BAR0. The host programs DMABASE and then
//   DMACTRL (TLP count); the engine emits that many 128-byte 3DW MWr TLPs to
//   DMABASE+DATA_OFF onwards, followed by one 8-byte MWr of TOKEN at DMABASE
//   to tell the host the transfer is complete.
//
//   Build option: DMA_MSI_EN adds msiReq_out/msiAck_in and an MSI handshake
//   state after the token TLP. Without it the token EOP returns to IDLE.
//
// Ports
//   clk_in, reset_in        PCIe core clock, synchronous active-high reset
//   cfgBusDev_in[12:0]      requester {bus,dev}; function 0 appended
//   ctlWrEn_in/ctlReg_in/ctlData_in   register write (0=DMABASE, 1=DMACTRL)
//   srcData_in/srcValid_in/srcReady_out  64-bit payload stream
//   txData_out/txValid_out/txReady_in/txSOP_out/txEOP_out  Avalon-ST TX
//   busy_out                transfer in progress
//   tlpCount_out[15:0]      data TLPs completed, wrapping
//   msiReq_out/msiAck_in    (DMA_MSI_EN only) completion interrupt handshake
//
// state | meaning
// IDLE  | waiting for DMACTRL; DMABASE writable
// HDR0  | data TLP header QW0 {DW1,DW0}, SOP
// HDR1  | data TLP header QW1 {0,addr}
// DATA  | 16 payload beats passed straight from the source stream
// TOK0  | token TLP header QW0, SOP
// TOK1  | token TLP header QW1 {0,DMABASE}
// TOKD  | token payload QW, EOP
// MSIW  | (DMA_MSI_EN) holding msiReq_out until msiAck_in

module dma_wr_engine #(
  parameter logic [63:0] TOKEN    = 64'hCAFE_F00D_C0DE_FACE,
  parameter logic [31:0] DATA_OFF = 32'h40
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [12:0] cfgBusDev_in,
  input  logic        ctlWrEn_in,
  input  logic        ctlReg_in,
  input  logic [31:0] ctlData_in,
  input  logic [63:0] srcData_in,
  input  logic        srcValid_in,
  output logic        srcReady_out,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  input  logic        txReady_in,
  output logic        txSOP_out,
  output logic        txEOP_out,
  output logic        busy_out,
`ifdef DMA_MSI_EN
  output logic        msiReq_out,
  input  logic        msiAck_in,
`endif
  output logic [15:0] tlpCount_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_TOK0, S_TOK1, S_TOKD
`ifdef DMA_MSI_EN
    , S_MSIW
`endif
  } state_t;

  localparam logic [31:0] DW0_DATA = 32'h4000_0020;  // 3DW MWr, 32 DW
  localparam logic [31:0] DW0_TOK  = 32'h4000_0002;  // 3DW MWr, 2 DW

  state_t      r_state;
  logic [31:0] r_base;
  logic [31:0] r_addr;
  logic [7:0]  r_remaining;
  logic [3:0]  r_beat;
  logic [15:0] r_tlp_count;
`ifdef DMA_MSI_EN
  logic        r_msi_req;
`endif

  logic        w_accept;
  logic [31:0] w_dw1;

  // Requester ID with function 0, tag 0, last/first BE = 0xF.
  assign w_dw1    = {cfgBusDev_in, 3'b000, 8'h00, 8'hFF};
  assign w_accept = txValid_out & txReady_in;

  assign busy_out     = (r_state != S_IDLE);
  assign tlpCount_out = r_tlp_count;
`ifdef DMA_MSI_EN
  assign msiReq_out   = r_msi_req;
`endif

  // Beat contents are a pure function of state, so they stay put while the
  // TX port stalls. DATA is a direct pass-through of the source handshake.
  always_comb begin
    txData_out   = 64'h0;
    txValid_out  = 1'b0;
    txSOP_out    = 1'b0;
    txEOP_out    = 1'b0;
    srcReady_out = 1'b0;
    case (r_state)
      S_HDR0: begin
        txData_out  = {w_dw1, DW0_DATA};
        txValid_out = 1'b1;
        txSOP_out   = 1'b1;
      end
      S_HDR1: begin
        txData_out  = {32'h0, r_addr};
        txValid_out = 1'b1;
      end
      S_DATA: begin
        txData_out   = srcData_in;
        txValid_out  = srcValid_in;
        srcReady_out = txReady_in;
        txEOP_out    = (r_beat == 4'hF);
      end
      S_TOK0: begin
        txData_out  = {w_dw1, DW0_TOK};
        txValid_out = 1'b1;
        txSOP_out   = 1'b1;
      end
      S_TOK1: begin
        txData_out  = {32'h0, r_base};
        txValid_out = 1'b1;
      end
      S_TOKD: begin
        txData_out  = TOKEN;
        txValid_out = 1'b1;
        txEOP_out   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= S_IDLE;
      r_base      <= 32'h0;
      r_addr      <= 32'h0;
      r_remaining <= 8'h0;
      r_beat      <= 4'h0;
      r_tlp_count <= 16'h0;
`ifdef DMA_MSI_EN
      r_msi_req   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctlWrEn_in) begin
            if (!ctlReg_in) begin
              r_base <= ctlData_in & 32'hFFFF_FFF8;
            end else if (ctlData_in[7:0] != 8'h0) begin
              r_remaining <= ctlData_in[7:0];
              r_addr      <= r_base + DATA_OFF;
              r_beat      <= 4'h0;
              r_state     <= S_HDR0;
            end
          end
        end
        S_HDR0: if (w_accept) r_state <= S_HDR1;
        S_HDR1: if (w_accept) r_state <= S_DATA;
        S_DATA: begin
          if (w_accept) begin
            r_beat <= r_beat + 4'd1;
            if (r_beat == 4'hF) begin
              r_remaining <= r_remaining - 8'd1;
              r_addr      <= r_addr + 32'd128;
              r_tlp_count <= r_tlp_count + 16'd1;
              // r_remaining still holds the pre-decrement count here
              r_state     <= (r_remaining > 8'd1) ? S_HDR0 : S_TOK0;
            end
          end
        end
        S_TOK0: if (w_accept) r_state <= S_TOK1;
        S_TOK1: if (w_accept) r_state <= S_TOKD;
        S_TOKD: begin
          if (w_accept) begin
`ifdef DMA_MSI_EN
            r_msi_req <= 1'b1;
            r_state   <= S_MSIW;
`else
            r_state   <= S_IDLE;
`endif
          end
        end
`ifdef DMA_MSI_EN
        S_MSIW: begin
          if (msiAck_in) begin
            r_msi_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_wr_engine.sv
module tb_dma_wr_engine;

  localparam logic [63:0] TOKEN = 64'hCAFE_F00D_C0DE_FACE;
  localparam logic [63:0] RAMP  = 64'h5A00_0000_0000_0000;
  localparam logic [12:0] BDF   = 13'h1A5B;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [12:0] cfgBusDev_in = BDF;
  logic        ctlWrEn_in = 1'b0;
  logic        ctlReg_in = 1'b0;
  logic [31:0] ctlData_in = 32'h0;
  logic [63:0] srcData_in = 64'h0;
  logic        srcValid_in = 1'b0;
  logic        srcReady_out;
  logic [63:0] txData_out;
  logic        txValid_out;
  logic        txReady_in = 1'b0;
  logic        txSOP_out;
  logic        txEOP_out;
  logic        busy_out;
  logic [15:0] tlpCount_out;

  dma_wr_engine dut (
    .clk_in       (clk),
    .reset_in     (reset_in),
    .cfgBusDev_in (cfgBusDev_in),
    .ctlWrEn_in   (ctlWrEn_in),
    .ctlReg_in    (ctlReg_in),
    .ctlData_in   (ctlData_in),
    .srcData_in   (srcData_in),
    .srcValid_in  (srcValid_in),
    .srcReady_out (srcReady_out),
    .txData_out   (txData_out),
    .txValid_out  (txValid_out),
    .txReady_in   (txReady_in),
    .txSOP_out    (txSOP_out),
    .txEOP_out    (txEOP_out),
    .busy_out     (busy_out),
    .tlpCount_out (tlpCount_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int src_k  = 0;
  int gap_cnt, hold_err;
  bit timed_out;
  logic [65:0] cap_q[$];   // {sop, eop, data}
  logic [65:0] exp_q[$];

  function automatic logic [31:0] dw1();
    return {BDF, 3'b000, 8'h00, 8'hFF};
  endfunction

  // Reference beat stream for one transfer of n data TLPs from base.
  function automatic void build_exp(input logic [31:0] base, input int n, input int k0);
    logic [31:0] addr;
    exp_q.delete();
    addr = base + 32'h40;
    for (int t = 0; t < n; t++) begin
      exp_q.push_back({1'b1, 1'b0, dw1(), 32'h4000_0020});
      exp_q.push_back({2'b00, 32'h0, addr});
      for (int b = 0; b < 16; b++)
        exp_q.push_back({1'b0, (b == 15), RAMP + 64'(k0 + t*16 + b)});
      addr = addr + 32'd128;
    end
    exp_q.push_back({1'b1, 1'b0, dw1(), 32'h4000_0002});
    exp_q.push_back({2'b00, 32'h0, base});
    exp_q.push_back({1'b0, 1'b1, TOKEN});
  endfunction

  task automatic ctl_write(input logic r, input logic [31:0] d);
    @(negedge clk);
    txReady_in  = 1'b0;
    srcValid_in = 1'b0;
    ctlWrEn_in  = 1'b1;
    ctlReg_in   = r;
    ctlData_in  = d;
    @(negedge clk);
    ctlWrEn_in  = 1'b0;
  endtask

  // Drives the TX/source side and records every accepted beat until busy
  // drops, the abort beat index is reached, or the cycle budget runs out.
  task automatic capture(input int max_cycles, input bit stall, input int abort_at,
                         input bit inject_mid, input int inject_last_idx);
    bit prev_stall = 1'b0;
    logic [65:0] prev_beat = '0;
    logic [65:0] beat;
    cap_q.delete();
    gap_cnt = 0; hold_err = 0; timed_out = 1'b1;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      txReady_in  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      srcValid_in = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      srcData_in  = RAMP + 64'(src_k);
      ctlWrEn_in  = inject_mid && (cyc == 5 || cyc == 6);
      ctlReg_in   = (cyc == 6);
      ctlData_in  = (cyc == 6) ? 32'd5 : 32'h1000;
      #1;
      if (!busy_out) begin timed_out = 1'b0; break; end
      beat = {txSOP_out, txEOP_out, txData_out};
      if (prev_stall && txValid_out && beat !== prev_beat) hold_err++;
      prev_stall = txValid_out && !txReady_in;
      prev_beat  = beat;
      if (!txValid_out) gap_cnt++;
      if (srcValid_in && srcReady_out) src_k++;
      if (txValid_out && txReady_in) begin
        cap_q.push_back(beat);
        if (cap_q.size() == inject_last_idx + 1 && txEOP_out) begin
          ctlWrEn_in = 1'b1; ctlReg_in = 1'b1; ctlData_in = 32'd1;
        end
        if (cap_q.size() == abort_at) begin timed_out = 1'b0; break; end
      end
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    #1;
    checks++;
    if ({txValid_out, srcReady_out, txSOP_out, txEOP_out, busy_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got v/rdy/sop/eop/busy=%b required 00000",
               {txValid_out, srcReady_out, txSOP_out, txEOP_out, busy_out});
    end
    checks++;
    if (txData_out !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h required 0", txData_out);
    end
    checks++;
    if (tlpCount_out !== 16'h0) begin
      errors++; $display("FAIL reset_count: got %0d required 0", tlpCount_out);
    end
  endtask

  task automatic test_single();
    int k0;
    ctl_write(1'b0, 32'h0000_0023);   // low bits must be dropped -> 0x20
    ctl_write(1'b1, 32'd1);
    #1;
    checks++;
    if (!(txValid_out === 1'b1 && txSOP_out === 1'b1 && busy_out === 1'b1 &&
          txData_out === {dw1(), 32'h4000_0020})) begin
      errors++;
      $display("FAIL single_latency: got v=%b sop=%b busy=%b data=%h required 1 1 1 %h",
               txValid_out, txSOP_out, busy_out, txData_out, {dw1(), 32'h4000_0020});
    end
    k0 = src_k;
    capture(500, 1'b0, -1, 1'b0, -1);
    build_exp(32'h20, 1, k0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL single_timeout: busy never dropped"); end
    checks++;
    if (cap_q.size() != 21) begin
      errors++; $display("FAIL single_len: got %0d beats required 21", cap_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tlpCount_out !== 16'd1 || busy_out !== 1'b0) begin
      errors++; $display("FAIL single_end: got count=%0d busy=%b required 1 0", tlpCount_out, busy_out);
    end
  endtask

  task automatic test_back_to_back();
    int k0;
    ctl_write(1'b1, 32'd3);
    k0 = src_k;
    capture(1000, 1'b0, -1, 1'b0, -1);
    build_exp(32'h20, 3, k0);
    checks++;
    if (timed_out || cap_q.size() != 57) begin
      errors++; $display("FAIL b2b_len: got %0d beats timeout=%b required 57", cap_q.size(), timed_out);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (gap_cnt != 0) begin
      errors++; $display("FAIL b2b_gaps: got %0d idle cycles required 0", gap_cnt);
    end
    checks++;
    if (tlpCount_out !== 16'd4) begin
      errors++; $display("FAIL b2b_count: got %0d required 4", tlpCount_out);
    end
  endtask

  task automatic test_stalls();
    int k0;
    ctl_write(1'b1, 32'd2);
    k0 = src_k;
    capture(3000, 1'b1, -1, 1'b0, -1);
    build_exp(32'h20, 2, k0);
    checks++;
    if (timed_out || cap_q.size() != 39) begin
      errors++; $display("FAIL stall_len: got %0d beats timeout=%b required 39", cap_q.size(), timed_out);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (hold_err != 0) begin
      errors++; $display("FAIL stall_hold: got %0d unstable stalled beats required 0", hold_err);
    end
    checks++;
    if (tlpCount_out !== 16'd6) begin
      errors++; $display("FAIL stall_count: got %0d required 6", tlpCount_out);
    end
  endtask

  task automatic test_ignored_writes();
    int k0;
    ctl_write(1'b1, 32'h0000_0100);   // count field [7:0] is zero
    #1;
    checks++;
    if (busy_out !== 1'b0 || txValid_out !== 1'b0) begin
      errors++; $display("FAIL zero_ctrl: got busy=%b valid=%b required 0 0", busy_out, txValid_out);
    end
    // busy-time DMABASE/DMACTRL writes, plus a DMACTRL on the token EOP cycle
    ctl_write(1'b1, 32'd1);
    k0 = src_k;
    capture(500, 1'b0, -1, 1'b1, 20);
    build_exp(32'h20, 1, k0);
    checks++;
    if (timed_out || cap_q.size() != 21) begin
      errors++; $display("FAIL busy_wr_len: got %0d beats timeout=%b required 21", cap_q.size(), timed_out);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL busy_wr_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (busy_out !== 1'b0 || txValid_out !== 1'b0 || tlpCount_out !== 16'd7) begin
      errors++;
      $display("FAIL eop_wr: got busy=%b valid=%b count=%0d required 0 0 7",
               busy_out, txValid_out, tlpCount_out);
    end
    ctl_write(1'b1, 32'd1);
    k0 = src_k;
    capture(500, 1'b0, -1, 1'b0, -1);
    build_exp(32'h20, 1, k0);
    checks++;
    if (timed_out || cap_q.size() != 21) begin
      errors++; $display("FAIL base_kept_len: got %0d beats required 21", cap_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL base_kept_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    int k0;
    ctl_write(1'b0, 32'hFFFF_FFA0);
    ctl_write(1'b1, 32'd2);
    k0 = src_k;
    capture(1000, 1'b0, -1, 1'b0, -1);
    build_exp(32'hFFFF_FFA0, 2, k0);
    checks++;
    if (timed_out || cap_q.size() != 39) begin
      errors++; $display("FAIL wrap_len: got %0d beats required 39", cap_q.size());
    end
    checks++;
    if (cap_q.size() > 19 && (cap_q[1][31:0] !== 32'hFFFF_FFE0 || cap_q[19][31:0] !== 32'h0000_0060)) begin
      errors++; $display("FAIL wrap_addr: got %h %h required ffffffe0 00000060",
                         cap_q[1][31:0], cap_q[19][31:0]);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tlpCount_out !== 16'd10) begin
      errors++; $display("FAIL wrap_count: got %0d required 10", tlpCount_out);
    end
  endtask

  task automatic test_reset_mid();
    int k0;
    ctl_write(1'b1, 32'd1);
    capture(500, 1'b0, 10, 1'b0, -1);  // stop on data beat 7
    reset_in = 1'b1;
    checks++;
    if (timed_out || cap_q.size() != 10) begin
      errors++; $display("FAIL abort_reach: got %0d beats required 10", cap_q.size());
    end
    @(negedge clk); #1;
    checks++;
    if (txValid_out !== 1'b0 || srcReady_out !== 1'b0 || busy_out !== 1'b0 || tlpCount_out !== 16'd0) begin
      errors++;
      $display("FAIL abort_state: got valid=%b rdy=%b busy=%b count=%0d required 0 0 0 0",
               txValid_out, srcReady_out, busy_out, tlpCount_out);
    end
    reset_in = 1'b0;
    ctl_write(1'b1, 32'd1);
    k0 = src_k;
    capture(500, 1'b0, -1, 1'b0, -1);
    build_exp(32'h0, 1, k0);           // DMABASE was cleared by reset
    checks++;
    if (timed_out || cap_q.size() != 21) begin
      errors++; $display("FAIL fresh_len: got %0d beats required 21", cap_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fresh_beat%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tlpCount_out !== 16'd1) begin
      errors++; $display("FAIL fresh_count: got %0d required 1", tlpCount_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stalls();
    test_ignored_writes();
    test_addr_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
